// File: rtl/chess_game_sequencer.sv
// ============================================================================
// chess_game_sequencer: game-level FSM that drives two player timers.
// Optional Fischer increment feature: define FISCHER_INC_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module chess_game_sequencer #(
  parameter int INC_SEC = 2,
  parameter int MOVE_W  = 10
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              CE,
  input  logic              START,
  input  logic              PAUSE,
  input  logic              BTN_P1,
  input  logic              BTN_P2,
  input  logic              OV1,
  input  logic              OV2,
  output logic              ENABLE1,
  output logic              ENABLE2,
  output logic              INC1,
  output logic              INC2,
  output logic              FLAG1,
  output logic              FLAG2,
  output logic              END,
  output logic [MOVE_W-1:0] MOVES,
  output logic [2:0]        STATE
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN1    = 3'd1,
    S_RUN2    = 3'd2,
    S_PAUSED  = 3'd3,
    S_INC     = 3'd4,
    S_FLAGGED = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [MOVE_W-1:0]   moves_q, moves_d;
  logic                saved_q, saved_d;     // 1: paused from RUN2
  logic                start_q, pause_q, btn1_q, btn2_q;
  logic                en1_q, en2_q, flag1_q, flag2_q, end_q;
  logic                en1_d, en2_d, flag1_d, flag2_d, end_d;
  logic                start_e, pause_e, btn1_e, btn2_e;
  logic [MOVE_W-1:0]   moves_inc;

  assign start_e   = START  & ~start_q;
  assign pause_e   = PAUSE  & ~pause_q;
  assign btn1_e    = BTN_P1 & ~btn1_q;
  assign btn2_e    = BTN_P2 & ~btn2_q;
  assign moves_inc = (&moves_q) ? moves_q : moves_q + MOVE_W'(1'b1);

`ifdef FISCHER_INC_EN
  logic       mover_q, mover_d;              // 1: player 2 just moved
  logic [3:0] cnt_q, cnt_d;
  logic       inc1_q, inc2_q, inc1_d, inc2_d;
`endif

  always_comb begin
    state_d = state_q;
    moves_d = moves_q;
    saved_d = saved_q;
    flag1_d = flag1_q;
    flag2_d = flag2_q;
`ifdef FISCHER_INC_EN
    mover_d = mover_q;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_e) begin
          state_d = S_RUN1;
          moves_d = '0;
        end
      end
      S_RUN1: begin
        if (OV1) begin
          state_d = S_FLAGGED;
          flag1_d = 1'b1;
        end else if (btn1_e) begin
          moves_d = moves_inc;
`ifdef FISCHER_INC_EN
          state_d = S_INC;
          mover_d = 1'b0;
          cnt_d   = 4'(INC_SEC);
`else
          state_d = S_RUN2;
`endif
        end else if (pause_e) begin
          state_d = S_PAUSED;
          saved_d = 1'b0;
        end
      end
      S_RUN2: begin
        if (OV2) begin
          state_d = S_FLAGGED;
          flag2_d = 1'b1;
        end else if (btn2_e) begin
          moves_d = moves_inc;
`ifdef FISCHER_INC_EN
          state_d = S_INC;
          mover_d = 1'b1;
          cnt_d   = 4'(INC_SEC);
`else
          state_d = S_RUN1;
`endif
        end else if (pause_e) begin
          state_d = S_PAUSED;
          saved_d = 1'b1;
        end
      end
      S_PAUSED: begin
        if (pause_e) begin
          state_d = saved_q ? S_RUN2 : S_RUN1;
        end else if (start_e) begin
          state_d = S_IDLE;
        end
      end
`ifdef FISCHER_INC_EN
      // Counter holds the pulses still to emit, including the current one.
      S_INC: begin
        if (cnt_q <= 4'd1) begin
          state_d = mover_q ? S_RUN1 : S_RUN2;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`endif
      S_FLAGGED: begin
        if (start_e) begin
          state_d = S_IDLE;
          flag1_d = 1'b0;
          flag2_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        flag1_d = 1'b0;
        flag2_d = 1'b0;
      end
    endcase

    en1_d = (state_d == S_RUN1);
    en2_d = (state_d == S_RUN2);
    end_d = flag1_d | flag2_d;
`ifdef FISCHER_INC_EN
    inc1_d = (state_d == S_INC) & ~mover_d;
    inc2_d = (state_d == S_INC) &  mover_d;
`endif
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q <= S_IDLE;
      moves_q <= '0;
      saved_q <= 1'b0;
      start_q <= 1'b0;
      pause_q <= 1'b0;
      btn1_q  <= 1'b0;
      btn2_q  <= 1'b0;
      en1_q   <= 1'b0;
      en2_q   <= 1'b0;
      flag1_q <= 1'b0;
      flag2_q <= 1'b0;
      end_q   <= 1'b0;
    end else if (CE) begin
      state_q <= state_d;
      moves_q <= moves_d;
      saved_q <= saved_d;
      start_q <= START;
      pause_q <= PAUSE;
      btn1_q  <= BTN_P1;
      btn2_q  <= BTN_P2;
      en1_q   <= en1_d;
      en2_q   <= en2_d;
      flag1_q <= flag1_d;
      flag2_q <= flag2_d;
      end_q   <= end_d;
    end
  end

`ifdef FISCHER_INC_EN
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      mover_q <= 1'b0;
      cnt_q   <= 4'd0;
      inc1_q  <= 1'b0;
      inc2_q  <= 1'b0;
    end else if (CE) begin
      mover_q <= mover_d;
      cnt_q   <= cnt_d;
      inc1_q  <= inc1_d;
      inc2_q  <= inc2_d;
    end
  end

  assign INC1 = inc1_q;
  assign INC2 = inc2_q;
`else
  assign INC1 = 1'b0;
  assign INC2 = 1'b0;
`endif

  assign ENABLE1 = en1_q;
  assign ENABLE2 = en2_q;
  assign FLAG1   = flag1_q;
  assign FLAG2   = flag2_q;
  assign END     = end_q;
  assign MOVES   = moves_q;
  assign STATE   = state_q;

endmodule

`default_nettype wire
